alarm_sequencer: RTL



---
 rtl/alarm_sequencer_if.sv | 23 ++
 rtl/alarm_sequencer.sv | 95 +++++++++
 2 files changed

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if: time/button inputs and alarm status outputs of the alarm sequencer
interface alarm_sequencer_if;
    logic       sec_tick;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [3:0] al_hours;
    logic [5:0] al_minutes;
    logic       toggle_pulse;
    logic       snooze_pulse;
    logic       al_on;
    logic       ringing;
    logic       snoozing;
    logic       buzzer_out;
    modport master (
        output sec_tick, hours, minutes, seconds, al_hours, al_minutes, toggle_pulse, snooze_pulse,
        input  al_on, ringing, snoozing, buzzer_out
    );
    modport slave (
        input  sec_tick, hours, minutes, seconds, al_hours, al_minutes, toggle_pulse, snooze_pulse,
        output al_on, ringing, snoozing, buzzer_out
    );
endinterface

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm lifecycle (off/armed/ringing/snoozed) with beep-gated buzzer tone
module alarm_sequencer #(
    parameter int TONE_HALF      = 5000,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic            clk,
    input  logic            reset,
    alarm_sequencer_if.slave bus
);
    typedef enum logic [1:0] {OFF = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZE = 2'd3} state_t;
    state_t      state, state_n;
    logic        match, match_q, trigger;
    logic [6:0]  ring_cnt, ring_cnt_n;
    logic [9:0]  snz_cnt, snz_cnt_n;
    logic [15:0] tone_cnt, tone_cnt_n;
    logic        tone, tone_n, beep, beep_n, tone_wrap, stay_ring;

    assign match   = (bus.hours == bus.al_hours) && (bus.minutes == bus.al_minutes) && (bus.seconds == 6'd0);
    assign trigger = match && !match_q;

    always_comb begin
        state_n    = state;
        ring_cnt_n = ring_cnt;
        snz_cnt_n  = snz_cnt;
        beep_n     = beep;
        case (state)
            OFF:     if (bus.toggle_pulse) state_n = ARMED;
            ARMED: begin
                if (bus.toggle_pulse) state_n = OFF;
                else if (trigger) begin
                    state_n    = RINGING;
                    ring_cnt_n = 7'd0;
                    beep_n     = 1'b1;
                end
            end
            RINGING: begin
                if (bus.toggle_pulse) state_n = ARMED;
                else if (bus.snooze_pulse) begin
                    state_n   = SNOOZE;
                    snz_cnt_n = 10'(SNOOZE_MIN * 60);
                end else if (bus.sec_tick) begin
                    ring_cnt_n = ring_cnt + 7'd1;
                    beep_n     = ~beep;
                    if (ring_cnt + 7'd1 == 7'(RING_TIMEOUT_S)) state_n = ARMED;
                end
            end
            SNOOZE: begin
                if (bus.toggle_pulse) state_n = OFF;
                else if (bus.sec_tick) begin
                    snz_cnt_n = snz_cnt - 10'd1;
                    if (snz_cnt == 10'd1) begin
                        state_n    = RINGING;
                        ring_cnt_n = 7'd0;
                        beep_n     = 1'b1;
                    end
                end
            end
        endcase
    end

    // Tone restarts from a cleared counter on every entry into RINGING
    assign stay_ring  = (state == RINGING) && (state_n == RINGING);
    assign tone_wrap  = tone_cnt == 16'(TONE_HALF - 1);
    assign tone_cnt_n = !stay_ring ? 16'd0 : tone_wrap ? 16'd0 : tone_cnt + 16'd1;
    assign tone_n     = !stay_ring ? 1'b0 : tone_wrap ? ~tone : tone;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= OFF;
            match_q        <= 1'b0;
            ring_cnt       <= 7'd0;
            snz_cnt        <= 10'd0;
            tone_cnt       <= 16'd0;
            tone           <= 1'b0;
            beep           <= 1'b0;
            bus.al_on      <= 1'b0;
            bus.ringing    <= 1'b0;
            bus.snoozing   <= 1'b0;
            bus.buzzer_out <= 1'b0;
        end else begin
            state          <= state_n;
            match_q        <= match;
            ring_cnt       <= ring_cnt_n;
            snz_cnt        <= snz_cnt_n;
            tone_cnt       <= tone_cnt_n;
            tone           <= tone_n;
            beep           <= beep_n;
            bus.al_on      <= state_n != OFF;
            bus.ringing    <= state_n == RINGING;
            bus.snoozing   <= state_n == SNOOZE;
            bus.buzzer_out <= (state_n == RINGING) && beep_n && tone_n;
        end
    end
endmodule
